// File: rtl/encoder_conditioner.sv
// Front end for one HB3 encoder. It synchronises and glitch-filters SA/SB, then produces the
// filtered levels, an SA rising-edge strobe, the quadrature direction and a saturating glitch count.
module encoder_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16,
    parameter int GLITCH_CNT_W  = 16
) (
    input  logic                    clock,
    input  logic                    system_reset,
    input  logic                    sa_raw,
    input  logic                    sb_raw,
    input  logic                    clear_glitch,
    output logic                    encoder_data,
    output logic                    sb_filt,
    output logic                    rise_strobe,
    output logic                    direction,
    output logic [GLITCH_CNT_W-1:0] glitch_count
);

    localparam int CNT_W = $clog2(FILTER_CYCLES) + 1;
    localparam int SUM_W = GLITCH_CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    // Index 0 is channel A (SA), index 1 is channel B (SB).
    logic [SYNC_STAGES-1:0]  sync_a_r;
    logic [SYNC_STAGES-1:0]  sync_b_r;
    logic [1:0]              sample_s;
    logic [1:0]              filt_r;
    logic [CNT_W-1:0]        cnt_r      [2];
    logic [CNT_W-1:0]        cnt_next_s [2];
    logic [1:0]              filt_next_s;
    logic [1:0]              glitch_s;
    logic                    rise_strobe_r;
    logic                    direction_r;
    logic [GLITCH_CNT_W-1:0] glitch_count_r;
    logic [SUM_W-1:0]        glitch_sum_s;

    assign sample_s = {sync_b_r[SYNC_STAGES-1], sync_a_r[SYNC_STAGES-1]};

    // Filter next-state: a run of differing samples that ends before the threshold is a glitch.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_next_s[i] = filt_r[i];
            cnt_next_s[i]  = {CNT_W{1'b0}};
            glitch_s[i]    = 1'b0;
            if (sample_s[i] == filt_r[i]) begin
                glitch_s[i] = (cnt_r[i] != {CNT_W{1'b0}});
            end else if (cnt_r[i] == CNT_LAST) begin
                filt_next_s[i] = sample_s[i];
            end else begin
                cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
    end

    // The extra top bit of the sum flags an overflow, so the count saturates instead of wrapping.
    always_comb begin
        glitch_sum_s = {1'b0, glitch_count_r} + SUM_W'(glitch_s[0]) + SUM_W'(glitch_s[1]);
    end

    // Synchronisers, filter state and all registered outputs.
    always_ff @(posedge clock) begin
        if (system_reset) begin
            sync_a_r       <= {SYNC_STAGES{1'b0}};
            sync_b_r       <= {SYNC_STAGES{1'b0}};
            filt_r         <= 2'b00;
            cnt_r[0]       <= {CNT_W{1'b0}};
            cnt_r[1]       <= {CNT_W{1'b0}};
            rise_strobe_r  <= 1'b0;
            direction_r    <= 1'b0;
            glitch_count_r <= {GLITCH_CNT_W{1'b0}};
        end else begin
            sync_a_r      <= {sync_a_r[SYNC_STAGES-2:0], sa_raw};
            sync_b_r      <= {sync_b_r[SYNC_STAGES-2:0], sb_raw};
            filt_r        <= filt_next_s;
            cnt_r[0]      <= cnt_next_s[0];
            cnt_r[1]      <= cnt_next_s[1];
            rise_strobe_r <= ~filt_r[0] & filt_next_s[0];
            // Direction samples the SB level from before this edge, even if SB also changes now.
            if (~filt_r[0] & filt_next_s[0]) begin
                direction_r <= ~filt_r[1];
            end else begin
                direction_r <= direction_r;
            end
            if (clear_glitch) begin
                glitch_count_r <= {GLITCH_CNT_W{1'b0}};
            end else if (glitch_sum_s[GLITCH_CNT_W]) begin
                glitch_count_r <= {GLITCH_CNT_W{1'b1}};
            end else begin
                glitch_count_r <= glitch_sum_s[GLITCH_CNT_W-1:0];
            end
        end
    end

    assign encoder_data = filt_r[0];
    assign sb_filt      = filt_r[1];
    assign rise_strobe  = rise_strobe_r;
    assign direction    = direction_r;
    assign glitch_count = glitch_count_r;

endmodule

// File: tb/tb_encoder_conditioner.sv
// Directed bench for encoder_conditioner: the default build, a 4-bit glitch counter build
// and a FILTER_CYCLES=1 build, all driven by the same pins.
module tb_encoder_conditioner;

    logic        clock = 1'b0;
    logic        system_reset;
    logic        sa_raw;
    logic        sb_raw;
    logic        clear_glitch;

    logic        enc_d, sbf_d, strb_d, dir_d;
    logic [15:0] gc_d;
    logic        enc_w, sbf_w, strb_w, dir_w;
    logic [3:0]  gc_w;
    logic        enc_f, sbf_f, strb_f, dir_f;
    logic [3:0]  gc_f;

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;
    int double_strobes = 0;
    logic prev_strobe = 1'b0;

    always #5 clock = ~clock;

    encoder_conditioner dut (
        .clock(clock), .system_reset(system_reset), .sa_raw(sa_raw), .sb_raw(sb_raw),
        .clear_glitch(clear_glitch), .encoder_data(enc_d), .sb_filt(sbf_d),
        .rise_strobe(strb_d), .direction(dir_d), .glitch_count(gc_d)
    );

    encoder_conditioner #(.GLITCH_CNT_W(4)) dut_w4 (
        .clock(clock), .system_reset(system_reset), .sa_raw(sa_raw), .sb_raw(sb_raw),
        .clear_glitch(clear_glitch), .encoder_data(enc_w), .sb_filt(sbf_w),
        .rise_strobe(strb_w), .direction(dir_w), .glitch_count(gc_w)
    );

    encoder_conditioner #(.FILTER_CYCLES(1), .GLITCH_CNT_W(4)) dut_f1 (
        .clock(clock), .system_reset(system_reset), .sa_raw(sa_raw), .sb_raw(sb_raw),
        .clear_glitch(clear_glitch), .encoder_data(enc_f), .sb_filt(sbf_f),
        .rise_strobe(strb_f), .direction(dir_f), .glitch_count(gc_f)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n edges; inputs and outputs are touched 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (strb_d) strobes++;
            if (strb_d && prev_strobe) double_strobes++;
            prev_strobe = strb_d;
        end
    endtask

    task automatic drive_phase(input logic a, input logic b, input int n);
        sa_raw = a;
        sb_raw = b;
        tick(n);
    endtask

    // Pulse SA high for 3 edges then low for 10: one glitch event per pulse.
    task automatic short_glitch();
        sa_raw = 1'b1;
        tick(3);
        sa_raw = 1'b0;
        tick(10);
    endtask

    initial begin
        system_reset = 1'b1;
        sa_raw       = 1'b0;
        sb_raw       = 1'b0;
        clear_glitch = 1'b0;
        tick(2);
        check_value("rst_enc", enc_d, 0);
        check_value("rst_sbf", sbf_d, 0);
        check_value("rst_strb", strb_d, 0);
        check_value("rst_dir", dir_d, 0);
        check_value("rst_gc", gc_d, 0);
        system_reset = 1'b0;
        tick(1);

        // Clean rising step: encoder_data and the strobe appear at edge 18 (edge 3 for FILTER_CYCLES=1).
        sa_raw = 1'b1;
        tick(2);
        check_value("f1_rise_e2", enc_f, 0);
        tick(1);
        check_value("f1_rise_e3", enc_f, 1);
        tick(14);
        check_value("rise_e17_enc", enc_d, 0);
        check_value("rise_e17_strb", strb_d, 0);
        tick(1);
        check_value("rise_e18_enc", enc_d, 1);
        check_value("rise_e18_strb", strb_d, 1);
        check_value("rise_dir_fwd", dir_d, 1);
        tick(1);
        check_value("rise_e19_strb", strb_d, 0);
        check_value("rise_e19_enc", enc_d, 1);

        // Clean falling step: same latency, no strobe.
        strobes = 0;
        sa_raw  = 1'b0;
        tick(17);
        check_value("fall_e17_enc", enc_d, 1);
        tick(1);
        check_value("fall_e18_enc", enc_d, 0);
        tick(2);
        check_value("fall_no_strobe", strobes, 0);

        // A 10-cycle pulse is rejected as one glitch; a simultaneous SA+SB pulse adds two.
        sa_raw = 1'b1;
        tick(10);
        sa_raw = 1'b0;
        tick(20);
        check_value("glitch_a_enc", enc_d, 0);
        check_value("glitch_a_gc", gc_d, 1);
        sa_raw = 1'b1;
        sb_raw = 1'b1;
        tick(10);
        sa_raw = 1'b0;
        sb_raw = 1'b0;
        tick(20);
        check_value("glitch_ab_gc", gc_d, 3);
        check_value("glitch_ab_sbf", sbf_d, 0);
        check_value("glitch_ab_gc_w4", gc_w, 3);
        check_value("f1_no_glitch", gc_f, 0);

        // Forward quadrature: SA rises while SB is low.
        strobes = 0;
        double_strobes = 0;
        for (int p = 0; p < 3; p++) begin
            drive_phase(1'b1, 1'b0, 200);
            drive_phase(1'b1, 1'b1, 200);
            drive_phase(1'b0, 1'b1, 200);
            drive_phase(1'b0, 1'b0, 200);
        end
        check_value("fwd_strobes", strobes, 3);
        check_value("fwd_dir", dir_d, 1);

        // Reverse quadrature: SA rises while SB is high.
        strobes = 0;
        for (int p = 0; p < 3; p++) begin
            drive_phase(1'b0, 1'b1, 200);
            drive_phase(1'b1, 1'b1, 200);
            drive_phase(1'b1, 1'b0, 200);
            drive_phase(1'b0, 1'b0, 200);
        end
        check_value("rev_strobes", strobes, 3);
        check_value("rev_dir", dir_d, 0);
        check_value("quad_no_double", double_strobes, 0);
        check_value("quad_gc_stable", gc_d, 3);

        // Twenty short glitches: the 4-bit counter saturates at 15, the 16-bit one reaches 23.
        for (int g = 0; g < 20; g++) short_glitch();
        check_value("sat_gc_w4", gc_w, 15);
        check_value("sat_gc_16", gc_d, 23);
        check_value("sat_f1_gc", gc_f, 0);
        check_value("sat_enc", enc_d, 0);

        // Clear coinciding with a glitch event (edge 6 after the pulse starts) wins.
        sa_raw = 1'b1;
        tick(3);
        sa_raw = 1'b0;
        tick(2);
        clear_glitch = 1'b1;
        tick(1);
        clear_glitch = 1'b0;
        check_value("clr_gc_16", gc_d, 0);
        check_value("clr_gc_w4", gc_w, 0);
        tick(5);
        check_value("clr_gc_hold", gc_d, 0);

        // Reset in the middle of a falling transition with encoder_data high.
        sa_raw = 1'b1;
        tick(18);
        check_value("pre_rst_enc", enc_d, 1);
        check_value("pre_rst_dir", dir_d, 1);
        tick(2);
        sa_raw = 1'b0;
        tick(12);
        check_value("mid_enc", enc_d, 1);
        sa_raw = 1'b1;
        system_reset = 1'b1;
        tick(1);
        check_value("mid_rst_enc", enc_d, 0);
        check_value("mid_rst_dir", dir_d, 0);
        check_value("mid_rst_strb", strb_d, 0);
        check_value("mid_rst_sbf", sbf_d, 0);
        check_value("mid_rst_gc", gc_d, 0);
        system_reset = 1'b0;
        strobes = 0;
        tick(17);
        check_value("post_rst_e17", enc_d, 0);
        tick(1);
        check_value("post_rst_e18_enc", enc_d, 1);
        check_value("post_rst_e18_strb", strb_d, 1);
        tick(3);
        check_value("post_rst_strobes", strobes, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
